// File: rtl/io_controller_if.sv
// I/O strobe interface between the CPU control unit (master) and the I/O responder (slave).
interface io_controller_if;
  logic [3:0] io_addr;
  logic       io_addr_read;
  logic       io_read;
  logic       io_write;
  logic       io_push;
  logic       io_store_retaddr;
  logic       io_push_retaddr;
  logic       io_push_ints;
  logic       io_push_int_addr;
  logic       io_interrupt;

  modport master (
    output io_addr, io_addr_read, io_read, io_write, io_push,
           io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    input  io_interrupt
  );

  modport slave (
    input  io_addr, io_addr_read, io_read, io_write, io_push,
           io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
    output io_interrupt
  );
endinterface

// File: rtl/io_controller.sv
// Memory-mapped I/O ports plus a four-line prioritised interrupt responder.
module io_controller #(
  parameter logic [15:0]  VECTOR_BASE = 16'hFFF0,
  parameter int unsigned  SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  io_controller_if.slave io,
  inout  wire  [15:0]  d_bus,
  inout  wire  [15:0]  a_bus,
  input  logic [63:0]  in_port,
  output logic [63:0]  out_port,
  output logic [3:0]   in_ack,
  output logic [3:0]   out_strobe,
  input  logic [3:0]   irq
);

  localparam int unsigned DW   = 16;
  localparam int unsigned NIRQ = 4;

  logic [3:0][DW-1:0]              out_q;
  logic [DW-1:0]                   rd_q;
  logic [DW-1:0]                   retaddr;
  logic [NIRQ-1:0]                 pending;
  logic [NIRQ-1:0]                 enable;
  logic [1:0]                      active_id;
  logic                            in_service;
  logic [SYNC_STAGES-1:0][NIRQ-1:0] sync_q;
  logic [NIRQ-1:0]                 irq_prev;

  logic            rd_en;
  logic            wr_en;
  logic            port_sel;
  logic [NIRQ-1:0] irq_s;
  logic [NIRQ-1:0] irq_rise;
  logic [NIRQ-1:0] req;
  logic [1:0]      irq_id;
  logic [DW-1:0]   rd_val;
  logic [NIRQ-1:0] pend_nxt;
  logic            d_oe;
  logic [DW-1:0]   d_val;
  logic [DW-1:0]   vec_addr;

  assign rd_en    = io.io_read & io.io_addr_read;
  assign wr_en    = io.io_write & io.io_addr_read;
  assign port_sel = (io.io_addr[3:2] == 2'b00);
  assign irq_s    = sync_q[SYNC_STAGES-1];
  assign irq_rise = irq_s & ~irq_prev;
  assign req      = pending & enable;
  assign out_port = out_q;
  assign vec_addr = DW'(VECTOR_BASE + DW'(irq_id));

  // Lowest-numbered enabled pending line wins.
  always_comb begin
    irq_id = 2'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (req[i]) irq_id = 2'(i);
    end
  end

  // Register read mux; reflects state before any same-cycle write.
  always_comb begin
    rd_val = '0;
    case (io.io_addr)
      4'd0, 4'd1, 4'd2, 4'd3: rd_val = in_port[{io.io_addr[1:0], 4'b0000} +: DW];
      4'd12:                  rd_val = {14'b0, active_id};
      4'd13:                  rd_val = retaddr;
      4'd14:                  rd_val = {12'b0, pending};
      4'd15:                  rd_val = {12'b0, enable};
      default:                rd_val = '0;
    endcase
  end

  // Pending update: W1C and accept clear first, new edges set last so set wins.
  always_comb begin
    pend_nxt = pending;
    if (wr_en && io.io_addr == 4'd14) pend_nxt = pend_nxt & ~d_bus[NIRQ-1:0];
    if (io.io_store_retaddr && (|req)) pend_nxt[irq_id] = 1'b0;
    pend_nxt = pend_nxt | irq_rise;
  end

  // Data bus drive with fixed push priority.
  always_comb begin
    d_oe  = io.io_push | io.io_push_retaddr | io.io_push_ints;
    d_val = '0;
    if (io.io_push)              d_val = rd_q;
    else if (io.io_push_retaddr) d_val = retaddr;
    else if (io.io_push_ints)    d_val = {4'b0, in_service, active_id, 1'b0, enable, pending};
  end

  assign d_bus = d_oe ? d_val : {DW{1'bz}};
  assign a_bus = io.io_push_int_addr ? vec_addr : {DW{1'bz}};

  // IRQ synchroniser chain and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      irq_prev <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq};
      irq_prev <= irq_s;
    end
  end

  // Register file, port strobes and interrupt bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q           <= '0;
      rd_q            <= '0;
      retaddr         <= '0;
      pending         <= '0;
      enable          <= '0;
      active_id       <= '0;
      in_service      <= 1'b0;
      in_ack          <= '0;
      out_strobe      <= '0;
      io.io_interrupt <= 1'b0;
    end else begin
      in_ack          <= (rd_en && port_sel) ? (4'b0001 << io.io_addr[1:0]) : 4'b0000;
      out_strobe      <= (wr_en && port_sel) ? (4'b0001 << io.io_addr[1:0]) : 4'b0000;
      pending         <= pend_nxt;
      io.io_interrupt <= (|req) & ~in_service;
      if (rd_en) rd_q <= rd_val;
      if (wr_en) begin
        if (port_sel)             out_q[io.io_addr[1:0]] <= d_bus;
        if (io.io_addr == 4'd13)  retaddr <= d_bus;
        if (io.io_addr == 4'd15)  enable  <= d_bus[NIRQ-1:0];
      end
      if (io.io_push_retaddr) in_service <= 1'b0;
      if (io.io_store_retaddr) begin
        retaddr    <= d_bus;
        active_id  <= irq_id;
        in_service <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: port I/O, IRQ latency, priority, accept/return, bus arbitration.
module tb_io_controller;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_port;
  logic [63:0] out_port;
  logic [3:0]  in_ack;
  logic [3:0]  out_strobe;
  logic [3:0]  irq;
  wire  [15:0] d_bus;
  wire  [15:0] a_bus;
  logic [15:0] tb_d;
  logic        tb_d_en;
  logic [15:0] tb_a;
  logic        tb_a_en;

  int checks = 0;
  int errors = 0;

  io_controller_if bus ();

  assign d_bus = tb_d_en ? tb_d : 16'hzzzz;
  assign a_bus = tb_a_en ? tb_a : 16'hzzzz;

  io_controller #(.VECTOR_BASE(16'hFFF0), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .io         (bus),
    .d_bus      (d_bus),
    .a_bus      (a_bus),
    .in_port    (in_port),
    .out_port   (out_port),
    .in_ack     (in_ack),
    .out_strobe (out_strobe),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [15:0] data);
    bus.io_addr = addr; bus.io_addr_read = 1'b1; bus.io_write = 1'b1;
    tb_d = data; tb_d_en = 1'b1;
    tick();
    bus.io_addr_read = 1'b0; bus.io_write = 1'b0; tb_d_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] addr);
    bus.io_addr = addr; bus.io_addr_read = 1'b1; bus.io_read = 1'b1;
    tick();
    bus.io_addr_read = 1'b0; bus.io_read = 1'b0;
  endtask

  task automatic status(input string tag, input logic [15:0] exp);
    bus.io_push_ints = 1'b1;
    #1;
    chk(tag, 64'(d_bus), 64'(exp));
    bus.io_push_ints = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; irq = 4'hF; in_port = '0;
    tb_d = '0; tb_d_en = 1'b0; tb_a = '0; tb_a_en = 1'b0;
    bus.io_addr = '0; bus.io_addr_read = 1'b0; bus.io_read = 1'b0; bus.io_write = 1'b0;
    bus.io_push = 1'b0; bus.io_store_retaddr = 1'b0; bus.io_push_retaddr = 1'b0;
    bus.io_push_ints = 1'b0; bus.io_push_int_addr = 1'b0;
    repeat (3) tick();

    // Reset state, buses released
    chk("rst_irq", 64'(bus.io_interrupt), 64'd0);
    chk("rst_out_port", out_port, 64'd0);
    chk("rst_in_ack", 64'(in_ack), 64'd0);
    chk("rst_out_strobe", 64'(out_strobe), 64'd0);
    tb_d = 16'hA5A5; tb_d_en = 1'b1; tb_a = 16'h5A5A; tb_a_en = 1'b1;
    #1;
    chk("rst_d_bus_free", 64'(d_bus), 64'h0000_0000_0000_A5A5);
    chk("rst_a_bus_free", 64'(a_bus), 64'h0000_0000_0000_5A5A);
    tb_d_en = 1'b0; tb_a_en = 1'b0;

    // Release with irq held high and enable zero
    rst_n = 1'b1;
    repeat (6) tick();
    chk("no_irq_masked", 64'(bus.io_interrupt), 64'd0);
    status("status_pending_all", 16'h000F);
    irq = 4'h0;
    wr(4'd14, 16'h000F);
    status("status_w1c_all", 16'h0000);

    // Output port write
    wr(4'd2, 16'hBEEF);
    chk("out_port2", 64'(out_port[47:32]), 64'h0000_0000_0000_BEEF);
    chk("out_strobe_pulse", 64'(out_strobe), 64'h4);
    tick();
    chk("out_strobe_clear", 64'(out_strobe), 64'h0);

    // Input port read and push
    in_port[15:0] = 16'h1234;
    rd(4'd0);
    chk("in_ack_pulse", 64'(in_ack), 64'h1);
    bus.io_push = 1'b1;
    #1;
    chk("push_rd_q", 64'(d_bus), 64'h1234);
    bus.io_push = 1'b0;
    tick();
    chk("in_ack_clear", 64'(in_ack), 64'h0);

    // IRQ latency with irq[3] and irq[1] rising together
    wr(4'd15, 16'h000F);
    irq = 4'b1010;
    tick();
    chk("irq_lat_1", 64'(bus.io_interrupt), 64'd0);
    tick(); tick();
    chk("irq_lat_3", 64'(bus.io_interrupt), 64'd0);
    tick();
    chk("irq_lat_4", 64'(bus.io_interrupt), 64'd1);

    // Accept: vector for irq 1, capture PC
    bus.io_store_retaddr = 1'b1; bus.io_push_int_addr = 1'b1;
    tb_d = 16'h0042; tb_d_en = 1'b1;
    #1;
    chk("vector_irq1", 64'(a_bus), 64'hFFF1);
    tick();
    bus.io_store_retaddr = 1'b0; bus.io_push_int_addr = 1'b0; tb_d_en = 1'b0;
    status("status_accept1", 16'h0AF8);
    tick();
    chk("irq_drop_in_service", 64'(bus.io_interrupt), 64'd0);

    // Return then re-request for irq 3
    bus.io_push_retaddr = 1'b1;
    #1;
    chk("retaddr_push", 64'(d_bus), 64'h0042);
    tick();
    bus.io_push_retaddr = 1'b0;
    status("status_returned", 16'h02F8);
    tick();
    chk("irq_reassert", 64'(bus.io_interrupt), 64'd1);
    bus.io_push_int_addr = 1'b1;
    #1;
    chk("vector_irq3", 64'(a_bus), 64'hFFF3);
    bus.io_push_int_addr = 1'b0;
    wr(4'd14, 16'h0008);
    status("status_w1c3", 16'h02F0);

    // W1C on the same cycle a new irq[1] edge reaches the detector
    irq = 4'b1000;
    repeat (3) tick();
    irq = 4'b1010;
    tick(); tick();
    wr(4'd14, 16'h0002);
    status("w1c_set_wins", 16'h02F2);
    wr(4'd14, 16'h0002);
    status("w1c_plain", 16'h02F0);

    // Read and write same cycle: read sees old value
    bus.io_addr = 4'd15; bus.io_addr_read = 1'b1; bus.io_read = 1'b1; bus.io_write = 1'b1;
    tb_d = 16'h0005; tb_d_en = 1'b1;
    tick();
    bus.io_addr_read = 1'b0; bus.io_read = 1'b0; bus.io_write = 1'b0; tb_d_en = 1'b0;
    bus.io_push = 1'b1;
    #1;
    chk("rw_same_cycle_old", 64'(d_bus), 64'h000F);
    bus.io_push = 1'b0;
    rd(4'd15);
    bus.io_push = 1'b1;
    #1;
    chk("rw_same_cycle_new", 64'(d_bus), 64'h0005);
    bus.io_push = 1'b0;

    // Accept with nothing requesting
    bus.io_store_retaddr = 1'b1; tb_d = 16'h1357; tb_d_en = 1'b1;
    tick();
    bus.io_store_retaddr = 1'b0; tb_d_en = 1'b0;
    status("accept_empty", 16'h0850);

    // Push priority
    bus.io_push = 1'b1; bus.io_push_retaddr = 1'b1; bus.io_push_ints = 1'b1;
    #1;
    chk("prio_push", 64'(d_bus), 64'h0005);
    bus.io_push = 1'b0;
    #1;
    chk("prio_retaddr", 64'(d_bus), 64'h1357);
    bus.io_push_retaddr = 1'b0; bus.io_push_ints = 1'b0;
    tick();

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_port", out_port, 64'd0);
    chk("midrst_irq", 64'(bus.io_interrupt), 64'd0);
    status("midrst_status", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_controller.md
# io_controller

Memory-mapped I/O and interrupt responder sitting opposite the CPU control unit on the I/O strobe interface. Services port reads/writes, holds the interrupt return address, and presents the interrupt vector address when an interrupt is accepted. Prioritises and masks four external interrupt lines and drives `io_interrupt` back to the control unit.

## Interface
- `VECTOR_BASE`, 16'hFFF0, base of the 4-entry vector table; vector address = `VECTOR_BASE + irq_id`.
- `SYNC_STAGES`, 2, synchroniser depth on `irq` inputs (minimum 2).

- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `io_addr`  in  4  register address from control unit.
- `io_addr_read`  in  1  qualifies `io_addr`; `io_read`/`io_write` ignored when low.
- `io_read`  in  1  capture addressed register into read latch.
- `io_write`  in  1  write `d_bus` into addressed register.
- `io_push`  in  1  drive read latch onto `d_bus`.
- `io_store_retaddr`  in  1  interrupt accept: capture `d_bus` (PC) as return address.
- `io_push_retaddr`  in  1  drive return address onto `d_bus` (RIT).
- `io_push_ints`  in  1  drive interrupt status word onto `d_bus`.
- `io_push_int_addr`  in  1  drive vector address onto `a_bus`.
- `io_interrupt`  out  1  registered interrupt request to control unit.
- `d_bus`  inout  16  shared data bus; high-Z unless pushing.
- `a_bus`  inout  16  shared memory address bus; high-Z unless `io_push_int_addr`.
- `in_port`  in  64  four 16-bit input ports, port k = bits [16k+15:16k].
- `out_port`  out  64  four 16-bit output registers, same packing.
- `in_ack`  out  4  one-cycle pulse, port k read.
- `out_strobe`  out  4  one-cycle pulse, port k written.
- `irq`  in  4  asynchronous interrupt lines, rising-edge sensitive.

## Operation
- Address map: 0–3 input ports (read) / output ports (write); 12 active irq id (read, bits [1:0]); 13 return address (read/write); 14 pending (read; write-1-to-clear bits [3:0]); 15 enable mask (read/write bits [3:0]); others read 0, writes ignored.
- Read: `io_read & io_addr_read` latches addressed value into `rd_q`; reading 0–3 pulses `in_ack[k]` next cycle.
- Write: `io_write & io_addr_read` samples `d_bus`; writing 0–3 updates `out_port[k]` and pulses `out_strobe[k]` next cycle.
- IRQ path: `SYNC_STAGES` flops, then edge detect; rising edge sets `pending[k]`.
- Request: `io_interrupt <= |(pending & enable) & ~in_service`.
- Priority: lowest set bit of `pending & enable` is `irq_id`.
- Accept (`io_store_retaddr`): `retaddr <= d_bus`, `active_id <= irq_id`, clear `pending[irq_id]`, set `in_service`. `a_bus` = `VECTOR_BASE + irq_id` while `io_push_int_addr`, combinational from current `irq_id`, 16-bit wrap.
- Return (`io_push_retaddr`): `d_bus = retaddr`; clear `in_service` at edge.
- Status word (`io_push_ints`): {4'b0, in_service, active_id[1:0], 1'b0, enable[3:0], pending[3:0]}.
- Bus drive priority if several push strobes high: `io_push` > `io_push_retaddr` > `io_push_ints`.

## Timing
- Reset: `out_port`, `retaddr`, `rd_q`, `pending`, `enable`, `active_id`, `in_service`, synchronisers = 0; `io_interrupt`, `in_ack`, `out_strobe` = 0; `d_bus`/`a_bus` high-Z. Reset mid-operation aborts all state immediately.
- Read: strobe at edge N latches; `io_push` high in cycle N+1 drives `rd_q` combinationally.
- Write: `d_bus` sampled at the edge ending the `io_write` cycle; `out_port` visible one cycle later.
- IRQ latency: edge on `irq` to `io_interrupt` high = `SYNC_STAGES` + 2 cycles.
- Same-cycle pending set and clear (W1C or accept) on same bit: set wins.
- `io_read` and `io_write` same cycle: write takes effect, `rd_q` captures pre-write value.
- Accept with `pending & enable` == 0: `retaddr` still captured, `active_id` = 0, `in_service` set.
- `io_interrupt` drops the cycle after accept (`in_service` set); re-asserts after return if requests remain.

## Test plan
- Reset with `irq`=4'hF held: all outputs 0, buses Z; release, `enable`=0 -> `io_interrupt` stays 0.
- `io_write` addr 2, `d_bus`=16'hBEEF -> `out_port[47:32]`=16'hBEEF, `out_strobe`=4'b0100 for one cycle.
- `in_port[15:0]`=16'h1234, `io_read` addr 0 then `io_push` -> `d_bus`=16'h1234, `in_ack`=4'b0001.
- `enable`=4'hF, `irq[3]` and `irq[1]` rise together -> `io_interrupt` after 4 cycles; accept with `d_bus`=16'h0042 -> `a_bus`=16'hFFF1, `pending`=4'b1000.
- `io_push_retaddr` after above -> `d_bus`=16'h0042; next cycle `in_service`=0, `io_interrupt` re-asserts for irq 3, vector 16'hFFF3.
- W1C addr 14 with 4'b0010 in same cycle as new `irq[1]` edge reaching detector -> `pending[1]` remains 1.
